// File: rtl/ctrl_bus_arbiter.sv
// ctrl_bus_arbiter
// Shares one control bus between two masters: the CPU (master 0) and the
// USB host interface (master 1). Arbitration is round-robin with a
// request/grant/release handshake. A starvation timeout takes the bus away
// from a master that holds it too long while the other master is waiting.
//
// Ports
//   mclk, rst                  clock (rising edge) and async active-high reset
//   m0_req/addr/read/write/wdata, m0_gnt   CPU request, bus signals, grant
//   m1_req/addr/read/write/wdata, m1_gnt   USB request, bus signals, grant
//   bus_addr/read/write/wdata  bus signals of the current owner, to the slaves
//   bus_rdata                  read data from the slaves
//   m_rdata                    bus_rdata passed straight through to both masters
//   timeout_err                one-cycle pulse when a grant is forcibly revoked
//   owner                      status: 00 idle, 01 master 0, 10 master 1
module ctrl_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              timeout_err,
  output logic [1:0]        owner
);

  // The state encoding is the same as the owner status code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_r;
  logic              m0_gnt_r;
  logic              m1_gnt_r;
  logic [1:0]        owner_r;
  logic              timeout_err_r;
  logic [7:0]        hold_cnt_r;
  logic              last_owner_r;
  logic              lock0_r;
  logic              lock1_r;
  logic              req0_s;
  logic              req1_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic              bus_read_s;
  logic              bus_write_s;
  logic [DATA_W-1:0] bus_wdata_s;

  // A revoked master stays locked out until its request has been seen low.
  assign req0_s = m0_req & ~lock0_r;
  assign req1_s = m1_req & ~lock1_r;

  // Arbitration FSM with registered grant, owner and timeout outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      m0_gnt_r      <= 1'b0;
      m1_gnt_r      <= 1'b0;
      owner_r       <= 2'b00;
      timeout_err_r <= 1'b0;
      hold_cnt_r    <= 8'd0;
      last_owner_r  <= 1'b1;
      lock0_r       <= 1'b0;
      lock1_r       <= 1'b0;
    end else begin
      timeout_err_r <= 1'b0;
      lock0_r       <= lock0_r & m0_req;
      lock1_r       <= lock1_r & m1_req;
      case (state_r)
        IDLE: begin
          hold_cnt_r <= 8'd0;
          // On a tie the master that did not own the bus last wins.
          if (req0_s && (!req1_s || last_owner_r)) begin
            state_r  <= OWN0;
            m0_gnt_r <= 1'b1;
            owner_r  <= 2'b01;
          end else if (req1_s) begin
            state_r  <= OWN1;
            m1_gnt_r <= 1'b1;
            owner_r  <= 2'b10;
          end else begin
            state_r  <= IDLE;
            m0_gnt_r <= 1'b0;
            m1_gnt_r <= 1'b0;
            owner_r  <= 2'b00;
          end
        end
        OWN0: begin
          // Release is checked first, so a release on the timeout cycle
          // is an ordinary handover without an error pulse.
          if (!m0_req) begin
            last_owner_r <= 1'b0;
            hold_cnt_r   <= 8'd0;
            m0_gnt_r     <= 1'b0;
            if (req1_s) begin
              state_r  <= OWN1;
              m1_gnt_r <= 1'b1;
              owner_r  <= 2'b10;
            end else begin
              state_r  <= IDLE;
              owner_r  <= 2'b00;
            end
          end else if (req1_s && (hold_cnt_r == TIMEOUT_C)) begin
            state_r       <= OWN1;
            m0_gnt_r      <= 1'b0;
            m1_gnt_r      <= 1'b1;
            owner_r       <= 2'b10;
            timeout_err_r <= 1'b1;
            lock0_r       <= 1'b1;
            last_owner_r  <= 1'b0;
            hold_cnt_r    <= 8'd0;
          end else if (req1_s) begin
            // Never passes TIMEOUT: reaching it forces the transfer above.
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        OWN1: begin
          if (!m1_req) begin
            last_owner_r <= 1'b1;
            hold_cnt_r   <= 8'd0;
            m1_gnt_r     <= 1'b0;
            if (req0_s) begin
              state_r  <= OWN0;
              m0_gnt_r <= 1'b1;
              owner_r  <= 2'b01;
            end else begin
              state_r  <= IDLE;
              owner_r  <= 2'b00;
            end
          end else if (req0_s && (hold_cnt_r == TIMEOUT_C)) begin
            state_r       <= OWN0;
            m0_gnt_r      <= 1'b1;
            m1_gnt_r      <= 1'b0;
            owner_r       <= 2'b01;
            timeout_err_r <= 1'b1;
            lock1_r       <= 1'b1;
            last_owner_r  <= 1'b1;
            hold_cnt_r    <= 8'd0;
          end else if (req0_s) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          m0_gnt_r   <= 1'b0;
          m1_gnt_r   <= 1'b0;
          owner_r    <= 2'b00;
          hold_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Bus multiplexer: drives the owner's signals to the bus. A write takes
  // priority over a read, and strobes are masked during the release cycle.
  always_comb begin
    bus_addr_s  = {ADDR_W{1'b0}};
    bus_wdata_s = {DATA_W{1'b0}};
    bus_read_s  = 1'b0;
    bus_write_s = 1'b0;
    case (state_r)
      OWN0: begin
        bus_addr_s  = m0_addr;
        bus_wdata_s = m0_wdata;
        bus_write_s = m0_req & m0_write;
        bus_read_s  = m0_req & m0_read & ~m0_write;
      end
      OWN1: begin
        bus_addr_s  = m1_addr;
        bus_wdata_s = m1_wdata;
        bus_write_s = m1_req & m1_write;
        bus_read_s  = m1_req & m1_read & ~m1_write;
      end
      default: begin
        bus_addr_s  = {ADDR_W{1'b0}};
        bus_wdata_s = {DATA_W{1'b0}};
        bus_read_s  = 1'b0;
        bus_write_s = 1'b0;
      end
    endcase
  end

  assign m0_gnt      = m0_gnt_r;
  assign m1_gnt      = m1_gnt_r;
  assign owner       = owner_r;
  assign timeout_err = timeout_err_r;
  assign bus_addr    = bus_addr_s;
  assign bus_read    = bus_read_s;
  assign bus_write   = bus_write_s;
  assign bus_wdata   = bus_wdata_s;
  assign m_rdata     = bus_rdata;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Testbench for ctrl_bus_arbiter (TIMEOUT = 4). A table of per-cycle input
// vectors with hand-derived expected outputs is applied in a loop; the
// expected outputs go through a scoreboard queue and are compared one clock
// edge later. Hand-written sequences cover async reset and the release cycle.
module tb_ctrl_bus_arbiter;

  localparam logic [7:0] A0 = 8'h12;
  localparam logic [7:0] D0 = 8'hA5;
  localparam logic [7:0] A1 = 8'h34;
  localparam logic [7:0] D1 = 8'h5A;
  localparam logic [7:0] Z8 = 8'h00;

  logic       mclk;
  logic       rst;
  logic       m0_req, m0_read, m0_write, m0_gnt;
  logic       m1_req, m1_read, m1_write, m1_gnt;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata, m_rdata;
  logic       bus_read, bus_write, timeout_err;
  logic [1:0] owner;

  typedef struct packed {
    logic       m0g;
    logic       m1g;
    logic       terr;
    logic [1:0] own;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  typedef struct packed {
    logic m0r;
    logic m1r;
    logic m0rd;
    logic m0wr;
    logic m1rd;
    logic m1wr;
    exp_t e;
  } vec_t;

  vec_t tbl [23];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ctrl_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .mclk(mclk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .m_rdata(m_rdata),
    .timeout_err(timeout_err), .owner(owner)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic m0r, m1r, m0rd, m0wr, m1rd, m1wr,
                              input logic m0g, m1g, terr, input logic [1:0] own,
                              input logic rd, wr, input logic [7:0] addr, wdata);
    vec_t v;
    v.m0r = m0r; v.m1r = m1r; v.m0rd = m0rd; v.m0wr = m0wr;
    v.m1rd = m1rd; v.m1wr = m1wr;
    v.e.m0g = m0g; v.e.m1g = m1g; v.e.terr = terr; v.e.own = own;
    v.e.rd = rd; v.e.wr = wr; v.e.addr = addr; v.e.wdata = wdata;
    return v;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.m0g = m0_gnt; a.m1g = m1_gnt; a.terr = timeout_err; a.own = owner;
    a.rd = bus_read; a.wr = bus_write; a.addr = bus_addr; a.wdata = bus_wdata;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input exp_t e);
    exp_t a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got m0g=%b m1g=%b terr=%b own=%b rd=%b wr=%b addr=%h wd=%h, expected m0g=%b m1g=%b terr=%b own=%b rd=%b wr=%b addr=%h wd=%h",
               nm, a.m0g, a.m1g, a.terr, a.own, a.rd, a.wr, a.addr, a.wdata,
               e.m0g, e.m1g, e.terr, e.own, e.rd, e.wr, e.addr, e.wdata);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    m0_req = v.m0r; m1_req = v.m1r;
    m0_read = v.m0rd; m0_write = v.m0wr;
    m1_read = v.m1rd; m1_write = v.m1wr;
    sb_q.push_back(v.e);
  endtask

  task automatic finish_vec(input string nm);
    exp_t e;
    @(posedge mclk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk_out(nm, e);
    end
  endtask

  initial begin
    // Rows: inputs (m0_req m1_req m0_rd m0_wr m1_rd m1_wr), then outputs one
    // edge later (m0_gnt m1_gnt timeout_err owner bus_read bus_write addr wdata).
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b1,A0,D0); // first grant m0, write
    tbl[1]  = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b1,A0,D0); // rd+wr -> wr only; m1 wr ignored
    tbl[2]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b1,1'b0,A0,D0); // read
    tbl[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8); // release -> idle
    tbl[4]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,A1,D1); // tie, last=0 -> m1
    tbl[5]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // handover, no bubble
    tbl[6]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 1
    tbl[7]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 2
    tbl[8]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 3
    tbl[9]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 4
    tbl[10] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,2'b10,1'b0,1'b0,A1,D1); // forced revoke
    tbl[11] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,2'b10,1'b0,1'b1,A1,D1); // pulse over, m1 writes
    tbl[12] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8); // m0 locked -> idle
    tbl[13] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8); // still locked
    tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8); // req low clears lock
    tbl[15] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // re-request granted
    tbl[16] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 1
    tbl[17] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 2
    tbl[18] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 3
    tbl[19] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0); // cnt 4
    tbl[20] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,A1,D1); // release at timeout: no err
    tbl[21] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8); // idle
    tbl[22] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,2'b10,1'b0,1'b1,A1,D1); // m1 owns, writing

    rst = 1'b1;
    m0_req = 1'b0; m0_read = 1'b0; m0_write = 1'b0;
    m1_req = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_addr = A0; m0_wdata = D0; m1_addr = A1; m1_wdata = D1;
    bus_rdata = 8'h00;

    #2;
    chk_out("reset_state", exp_t'(23'd0));
    @(posedge mclk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive_vec(tbl[i]);
      finish_vec($sformatf("row%0d", i));
    end

    // Async reset between edges while m1 owns the bus and is writing.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("async_rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("async_rst_owner", {30'd0, owner}, 32'd0);
    chk("async_rst_addr", {24'd0, bus_addr}, 32'd0);
    @(posedge mclk);
    #1;
    rst = 1'b0;

    // After reset a tie must go to master 0.
    drive_vec(mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,A0,D0));
    finish_vec("post_rst_tie");

    // Release cycle: owner strobes are masked while its req is low;
    // read data passes straight through in the same cycle.
    drive_vec(mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,Z8,Z8));
    bus_rdata = 8'h3C;
    #1;
    chk("release_mask_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("release_addr", {24'd0, bus_addr}, {24'd0, A0});
    chk("m_rdata_3c", {24'd0, m_rdata}, 32'h0000_003C);
    bus_rdata = 8'hC3;
    #1;
    chk("m_rdata_c3", {24'd0, m_rdata}, 32'h0000_00C3);
    finish_vec("release_to_idle");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d leftover entries, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_bus_arbiter.md
Name: ctrl_bus_arbiter

Overview:
- Shares the 8-bit control bus between two masters: the CPU (master 0) and the USB host interface (master 1).
- Sits between the masters and the bus slaves, such as the instruction memory loader.
- Arbitration is round-robin with request/grant/release handshaking.
- A starvation timeout forcibly revokes the grant from a master that holds the bus while the other waits.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
TIMEOUT, 255, max cycles a master may hold the grant while the other requests (1..255)

Ports:
mclk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
m0_req  in  1  CPU requests bus; held high for whole ownership
m0_addr  in  ADDR_W  CPU address
m0_read  in  1  CPU read strobe
m0_write  in  1  CPU write strobe
m0_wdata  in  DATA_W  CPU write data
m0_gnt  out  1  CPU owns bus
m1_req  in  1  USB requests bus
m1_addr  in  ADDR_W  USB address
m1_read  in  1  USB read strobe
m1_write  in  1  USB write strobe
m1_wdata  in  DATA_W  USB write data
m1_gnt  out  1  USB owns bus
bus_addr  out  ADDR_W  muxed address to slaves
bus_read  out  1  muxed read strobe
bus_write  out  1  muxed write strobe
bus_wdata  out  DATA_W  muxed write data
bus_rdata  in  DATA_W  slave read data
m_rdata  out  DATA_W  bus_rdata broadcast to both masters, combinational pass-through
timeout_err  out  1  one-cycle pulse on forced revoke
owner  out  2  00 idle, 01 master0, 10 master1 (debug/status)

Behaviour:
- States:
  - IDLE: no grant.
  - OWN0: m0_gnt=1.
  - OWN1: m1_gnt=1.
  - All gnt outputs are registered, one-hot or zero, never both high.
- Reset (async, rst=1):
  - State IDLE; m0_gnt=m1_gnt=0; owner=00; timeout_err=0; hold counter=0; last_owner=1, so master 0 wins the first tie.
  - Bus outputs are 0 while in IDLE.
- IDLE transitions:
  - Only m0_req -> OWN0 next cycle.
  - Only m1_req -> OWN1 next cycle.
  - Both -> the master != last_owner.
  - Grant latency is exactly 1 cycle after req is sampled high.
- OWNx:
  - Grant is held while mx_req=1.
  - mx_req sampled 0: if the other master requests, hand over directly (OWNy next cycle, no IDLE bubble); otherwise go to IDLE.
  - last_owner <= x on leaving OWNx.
- Bus mux (combinational):
  - OWN0 -> m0 signals; OWN1 -> m1 signals; IDLE -> all zero.
  - Strobes of the non-owning master are ignored.
  - Owner asserting read and write together: bus_write passes, bus_read forced 0.
  - While the owner's req is 0 (release cycle), its strobes are masked to 0.
- Hold counter:
  - Cleared on every grant change.
  - In OWNx, increments each cycle the other master's req=1; saturates at TIMEOUT.
- Timeout:
  - Counter == TIMEOUT with the other master still requesting -> forced transfer to OWNy next cycle.
  - timeout_err pulses 1 cycle, coincident with the new grant.
  - last_owner <= x.
  - The revoked master must drop req and re-request; its req is ignored until sampled low once, tracked by a per-master lockout flag cleared when req=0.
- Simultaneous release and timeout in the same cycle: treated as a normal release, no timeout_err.
- Reset mid-transfer: grants drop immediately (async); any in-flight strobe is aborted; no recovery required.
- owner is registered and tracks state.

Test Plan:
- Reset, then m0_req=1 at cycle 0 -> m0_gnt=1 at cycle 1, owner=01. m0_addr=0x12, m0_write=1, m0_wdata=0xA5 -> bus_addr=0x12, bus_write=1, bus_wdata=0xA5.
- From IDLE with last_owner=0, m0_req and m1_req rise together -> m1_gnt=1 next cycle. m1 releases -> m0_gnt=1 on the next cycle with no IDLE cycle between.
- TIMEOUT=4: m0 owns, m1_req held high -> after 4 counted cycles m1_gnt=1, m0_gnt=0, timeout_err=1 for exactly 1 cycle. m0_req kept high -> no regrant to m0 until m0_req drops and rises again.
- Owner drives m0_read=1 and m0_write=1 -> bus_write=1, bus_read=0. Non-owner m1_write=1 -> bus_write unaffected. bus_rdata=0x3C -> m_rdata=0x3C in the same cycle.
- Assert rst asynchronously mid-OWN1 (between clock edges) -> m1_gnt=0 and bus strobes=0 immediately. After release, a simultaneous request grants m0 first.
- m0 drops req on the exact cycle the counter hits TIMEOUT while m1 requests -> m1_gnt=1 next cycle, timeout_err stays 0.
